// File: rtl/rpm_sched_pkg.sv
// Shared types and helpers for the RPM round-robin scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rpm_sched_pkg;

    // Service FSM: grant in IDLE, reload target in LOAD, slew cur in STEP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2
    } state_e;

    localparam int RPM_MAX_DEF   = 12000;
    localparam int SLEW_STEP_DEF = 500;

    // Saturating mix: dir - alt clamped to [0, max]. Callers pass dir/alt
    // already sign-extended to 32 bits. The difference of two RPM_W-bit
    // signed words always fits in RPM_W+1 bits, so 32 bits cannot overflow.
    function automatic logic [31:0] sat_mix(input logic signed [31:0] dir,
                                             input logic signed [31:0] alt,
                                             input int                 max);
        logic signed [31:0] diff;
        diff = dir - alt;
        if (diff < 0) begin
            return 32'd0;
        end else if (diff > max) begin
            return 32'(max);
        end
        return 32'(diff);
    endfunction

endpackage

// File: rtl/rpm_mix_slew.sv
// Shared combinational datapath: saturated target mix and one bounded slew step.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the scheduler decides when the results are written.
module rpm_mix_slew
    import rpm_sched_pkg::*;
#(
    parameter int RPM_W     = 16,
    parameter int RPM_MAX   = RPM_MAX_DEF,
    parameter int SLEW_STEP = SLEW_STEP_DEF
) (
    input  logic [RPM_W-1:0] dir_i,
    input  logic [RPM_W-1:0] alt_i,
    input  logic [RPM_W-1:0] tgt_i,
    input  logic [RPM_W-1:0] cur_i,
    output logic [RPM_W-1:0] tgt_o,
    output logic [RPM_W-1:0] cur_o
);

    localparam logic [RPM_W-1:0] STEP_MAX = RPM_W'(SLEW_STEP);

    logic signed [31:0] dir_s;
    logic signed [31:0] alt_s;
    logic [RPM_W-1:0]   gap;

    // Mix the buffered command into a target and move cur toward tgt by at most one step.
    always_comb begin
        dir_s = {{(32-RPM_W){dir_i[RPM_W-1]}}, dir_i};
        alt_s = {{(32-RPM_W){alt_i[RPM_W-1]}}, alt_i};
        tgt_o = RPM_W'(sat_mix(dir_s, alt_s, RPM_MAX));
        gap   = '0;
        cur_o = cur_i;
        if (tgt_i >= cur_i) begin
            gap   = tgt_i - cur_i;
            cur_o = cur_i + ((gap > STEP_MAX) ? STEP_MAX : gap);
        end else begin
            gap   = cur_i - tgt_i;
            cur_o = cur_i - ((gap > STEP_MAX) ? STEP_MAX : gap);
        end
    end

endmodule

// File: rtl/rpm_sched.sv
// Round-robin scheduler sharing one mix/slew datapath across N_MOTOR motors.
// Latency: command accept to motor_rpm/rpm_upd update is 3 cycles; one service per 3 cycles.
// Backpressure: cmd_ready drops while the addressed motor's slot is full or while disarmed.
module rpm_sched
    import rpm_sched_pkg::*;
#(
    parameter int N_MOTOR   = 4,
    parameter int RPM_W     = 16,
    parameter int RPM_MAX   = RPM_MAX_DEF,
    parameter int SLEW_STEP = SLEW_STEP_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [$clog2(N_MOTOR)-1:0] cmd_motor,
    input  logic [RPM_W-1:0]           cmd_dir,
    input  logic [RPM_W-1:0]           cmd_alt,
    output logic [N_MOTOR*RPM_W-1:0]   motor_rpm,
    output logic [N_MOTOR-1:0]         rpm_upd,
    output logic                       busy
);

    localparam int IDX_W = $clog2(N_MOTOR);

    state_e             state_q;
    logic [IDX_W-1:0]   g_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic [N_MOTOR-1:0] slot_full_q;
    logic [N_MOTOR-1:0] rpm_upd_q;
    logic [RPM_W-1:0]   dir_q [N_MOTOR];
    logic [RPM_W-1:0]   alt_q [N_MOTOR];
    logic [RPM_W-1:0]   tgt_q [N_MOTOR];
    logic [RPM_W-1:0]   cur_q [N_MOTOR];

    logic [N_MOTOR-1:0] elig;
    logic               any_elig;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;
    logic               sel_full;
    logic               motor_ok;
    logic [RPM_W-1:0]   tgt_d;
    logic [RPM_W-1:0]   cur_d;

    // Ready when the addressed motor exists, its slot is empty and we are armed.
    always_comb begin
        sel_full = 1'b0;
        motor_ok = 1'b0;
        for (int m = 0; m < N_MOTOR; m++) begin
            if (cmd_motor == IDX_W'(m)) begin
                motor_ok = 1'b1;
                sel_full = slot_full_q[m];
            end
        end
        cmd_ready = arm && motor_ok && !sel_full;
    end

    // A motor needs service if it has a new command or has not reached its target.
    always_comb begin
        elig = '0;
        for (int m = 0; m < N_MOTOR; m++) begin
            elig[m] = slot_full_q[m] || (cur_q[m] != tgt_q[m]);
        end
    end

    // Round-robin pick: first eligible motor after the last grant, wrapping.
    always_comb begin
        any_elig = 1'b0;
        win      = '0;
        cand     = '0;
        for (int k = 1; k <= N_MOTOR; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % N_MOTOR);
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                win      = cand;
            end
        end
    end

    rpm_mix_slew #(
        .RPM_W     (RPM_W),
        .RPM_MAX   (RPM_MAX),
        .SLEW_STEP (SLEW_STEP)
    ) u_mix_slew (
        .dir_i (dir_q[g_q]),
        .alt_i (alt_q[g_q]),
        .tgt_i (tgt_q[g_q]),
        .cur_i (cur_q[g_q]),
        .tgt_o (tgt_d),
        .cur_o (cur_d)
    );

    // Service FSM plus command capture; disarm overrides targets and slots last.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            g_q          <= '0;
            last_grant_q <= IDX_W'(N_MOTOR - 1);
            slot_full_q  <= '0;
            rpm_upd_q    <= '0;
            for (int m = 0; m < N_MOTOR; m++) begin
                dir_q[m] <= '0;
                alt_q[m] <= '0;
                tgt_q[m] <= '0;
                cur_q[m] <= '0;
            end
        end else begin
            rpm_upd_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        g_q          <= win;
                        last_grant_q <= win;
                        state_q      <= LOAD;
                    end
                end
                LOAD: begin
                    if (slot_full_q[g_q]) begin
                        tgt_q[g_q]       <= tgt_d;
                        slot_full_q[g_q] <= 1'b0;
                    end
                    state_q <= STEP;
                end
                STEP: begin
                    cur_q[g_q]     <= cur_d;
                    rpm_upd_q[g_q] <= 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A slot being loaded is still full, so this never collides with LOAD's clear.
            if (cmd_valid && cmd_ready) begin
                slot_full_q[cmd_motor] <= 1'b1;
                dir_q[cmd_motor]       <= cmd_dir;
                alt_q[cmd_motor]       <= cmd_alt;
            end
            if (!arm) begin
                slot_full_q <= '0;
                for (int m = 0; m < N_MOTOR; m++) begin
                    tgt_q[m] <= '0;
                end
            end
        end
    end

    // Flatten current RPMs onto the output bus.
    always_comb begin
        motor_rpm = '0;
        for (int m = 0; m < N_MOTOR; m++) begin
            motor_rpm[m*RPM_W +: RPM_W] = cur_q[m];
        end
    end

    assign rpm_upd = rpm_upd_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rpm_sched.sv
// Self-checking bench for rpm_sched: directed scenarios plus randomized traffic.
// Latency: compares every cycle against a behavioural model of the scheduler.
// Backpressure: commands are held until cmd_ready, with bounded waits.
module tb_rpm_sched;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int RMAX = 12000;
    localparam int SLEW = 500;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           arm = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_motor = '0;
    logic [W-1:0]   cmd_dir = '0;
    logic [W-1:0]   cmd_alt = '0;
    logic [N*W-1:0] motor_rpm;
    logic [N-1:0]   rpm_upd;
    logic           busy;

    int checks = 0;
    int errors = 0;

    rpm_sched dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_motor (cmd_motor),
        .cmd_dir   (cmd_dir),
        .cmd_alt   (cmd_alt),
        .motor_rpm (motor_rpm),
        .rpm_upd   (rpm_upd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
    endtask

    function automatic logic [W-1:0] rpm_of(input int m);
        return motor_rpm[m*W +: W];
    endfunction

    // ---------------- behavioural model ----------------
    int     m_cur [N];
    int     m_tgt [N];
    int     m_dir [N];
    int     m_alt [N];
    bit     m_slot[N];
    int     m_last;
    int     m_g;
    int     m_busy_cyc;   // 0: free, 1: target reload pending, 2: slew pending
    bit [N-1:0] m_upd;
    bit     m_init = 1'b0;

    function automatic int mix(input int d, input int a);
        int r;
        r = d - a;
        if (r < 0) return 0;
        if (r > RMAX) return RMAX;
        return r;
    endfunction

    function automatic int slew(input int c, input int t);
        if (t > c) return (t - c > SLEW) ? c + SLEW : t;
        return (c - t > SLEW) ? c - SLEW : t;
    endfunction

    always @(posedge clk) begin
        int  mot;
        bit  acc;
        bit  found;
        if (reset) begin
            for (int m = 0; m < N; m++) begin
                m_cur[m] = 0; m_tgt[m] = 0; m_dir[m] = 0; m_alt[m] = 0; m_slot[m] = 0;
            end
            m_last = N - 1; m_g = 0; m_busy_cyc = 0; m_upd = '0; m_init = 1'b1;
        end else if (m_init) begin
            mot = int'(cmd_motor);
            acc = cmd_valid && arm && (mot < N) && !m_slot[mot];
            m_upd = '0;
            if (m_busy_cyc == 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (!found && (m_slot[c] || m_cur[c] != m_tgt[c])) begin
                        found = 1'b1; m_g = c; m_last = c; m_busy_cyc = 1;
                    end
                end
            end else if (m_busy_cyc == 1) begin
                if (m_slot[m_g]) begin
                    m_tgt[m_g] = mix(m_dir[m_g], m_alt[m_g]);
                    m_slot[m_g] = 1'b0;
                end
                m_busy_cyc = 2;
            end else begin
                m_cur[m_g] = slew(m_cur[m_g], m_tgt[m_g]);
                m_upd[m_g] = 1'b1;
                m_busy_cyc = 0;
            end
            if (acc) begin
                m_slot[mot] = 1'b1;
                m_dir[mot]  = int'($signed(cmd_dir));
                m_alt[mot]  = int'($signed(cmd_alt));
            end
            if (!arm) begin
                for (int m = 0; m < N; m++) begin
                    m_slot[m] = 1'b0; m_tgt[m] = 0;
                end
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [N*W-1:0] exp_rpm;
        if (m_init) begin
            for (int m = 0; m < N; m++) exp_rpm[m*W +: W] = W'(m_cur[m]);
            check("model_motor_rpm", motor_rpm, exp_rpm);
            check("model_rpm_upd",   rpm_upd,   m_upd);
            check("model_busy",      busy,      m_busy_cyc != 0);
            check("model_cmd_ready", cmd_ready, arm && !m_slot[int'(cmd_motor)]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send(input int m, input int d, input int a);
        bit done;
        done = 1'b0;
        cmd_valid = 1'b1;
        cmd_motor = 2'(m);
        cmd_dir   = W'(d);
        cmd_alt   = W'(a);
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (cmd_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!done) fail_now("send_timeout");
    endtask

    task automatic wait_upd(output logic [N-1:0] u, output int lat);
        u = '0;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (rpm_upd != '0) begin
                u = rpm_upd; lat = k;
                return;
            end
        end
        fail_now("wait_upd_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [N-1:0] u;
        int lat;

        // Reset state
        do_reset();
        check("reset_rpm",   motor_rpm, 0);
        check("reset_upd",   rpm_upd,   0);
        check("reset_busy",  busy,      0);
        check("reset_ready", cmd_ready, 1);

        // Single command: 300 - (-200) = 500, one step reaches it
        send(0, 300, -200);
        wait_upd(u, lat);
        check("single_latency", lat, 3);
        check("single_upd",     u, 4'b0001);
        check("single_rpm0",    rpm_of(0), 500);
        @(posedge clk); #1;
        check("single_upd_one_cycle", rpm_upd, 0);

        // Slew: 3000 reached in six 500-steps, 3 cycles apart
        do_reset();
        send(1, 3000, 0);
        for (int i = 1; i <= 6; i++) begin
            wait_upd(u, lat);
            check("slew_upd", u, 4'b0010);
            check("slew_lat", lat, 3);
            check("slew_rpm1", rpm_of(1), 500 * i);
        end
        check("slew_idle", busy, 0);

        // Saturation high: 15000 - (-1000) clamps to 12000
        do_reset();
        send(2, 15000, -1000);
        for (int i = 1; i <= 24; i++) wait_upd(u, lat);
        check("sat_hi_rpm2", rpm_of(2), 12000);
        check("sat_hi_idle", busy, 0);
        // Saturation low: 100 - 400 clamps to 0, ramp down by 500
        send(2, 100, 400);
        wait_upd(u, lat);
        check("sat_lo_rpm2_a", rpm_of(2), 11500);
        wait_upd(u, lat);
        check("sat_lo_rpm2_b", rpm_of(2), 11000);

        // Reset in the middle of that ramp
        do_reset();
        check("midreset_rpm",   motor_rpm, 0);
        check("midreset_upd",   rpm_upd,   0);
        check("midreset_busy",  busy,      0);
        check("midreset_ready", cmd_ready, 1);

        // Round-robin: right after motor 3 is granted, queue 3, 2, 0 back to back
        send(3, 3000, 0);
        wait_upd(u, lat);
        check("rr_pre_upd", u, 4'b1000);
        send(3, 3000, 0);
        send(2, 1000, 0);
        send(0, 1000, 0);
        check("rr_upd_3", rpm_upd, 4'b1000);
        cmd_motor = 2'd2;
        #1;
        check("rr_slot2_full_ready", cmd_ready, 0);
        wait_upd(u, lat);
        check("rr_order_0", u, 4'b0001);
        check("rr_rpm0", rpm_of(0), 500);
        wait_upd(u, lat);
        check("rr_order_2", u, 4'b0100);
        check("rr_rpm2", rpm_of(2), 500);
        wait_upd(u, lat);
        check("rr_order_3", u, 4'b1000);
        check("rr_rpm3", rpm_of(3), 1500);

        // Disarm: motor 0 at 2000 heading to 3000, then drop arm
        do_reset();
        send(0, 3000, 0);
        for (int i = 1; i <= 4; i++) wait_upd(u, lat);
        check("disarm_start", rpm_of(0), 2000);
        arm = 1'b0;
        cmd_valid = 1'b1;
        cmd_motor = 2'd1;
        cmd_dir = W'(4000);
        #1;
        check("disarm_ready", cmd_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            wait_upd(u, lat);
            check("disarm_ramp", rpm_of(0), 2000 - 500 * i);
        end
        check("disarm_idle", busy, 0);
        check("disarm_rpm1", rpm_of(1), 0);
        cmd_valid = 1'b0;
        arm = 1'b1;

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 2500; c++) begin
            int v;
            @(posedge clk); #1;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_motor = 2'($urandom_range(0, 3));
            v = int'($urandom_range(0, 17000)) - 2000;
            cmd_dir = W'(v);
            v = int'($urandom_range(0, 8000)) - 3000;
            cmd_alt = W'(v);
            if (arm) begin
                if ($urandom_range(0, 99) < 2) arm = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 10) arm = 1'b1;
            end
            reset = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        arm = 1'b1;
        cmd_valid = 1'b0;
        repeat (200) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
